// File: rtl/fat32_pkg.sv
// Shared FAT32 definitions: FSM state encodings, directory-entry layout and
// attribute masks used by the directory scan and cluster-chain stages.
package fat32_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_REQ,
    S_SCAN,
    S_LBA,
    S_DONE,
    S_FAIL
  } state_t;

  localparam int unsigned DIR_ENT_SZ = 32;
  localparam int unsigned SEC_BYTES  = 512;

  localparam logic [4:0] DIRENT_NAME0 = 5'd0;
  localparam logic [4:0] DIRENT_ATTR  = 5'd11;
  localparam logic [4:0] DIRENT_CLHI  = 5'd20;
  localparam logic [4:0] DIRENT_CLLO  = 5'd26;
  localparam logic [4:0] DIRENT_SIZE  = 5'd28;

  localparam logic [7:0] ATTR_VOL       = 8'h08;
  localparam logic [7:0] ATTR_DIR       = 8'h10;
  localparam logic [7:0] DIRENT_END     = 8'h00;
  localparam logic [7:0] DIRENT_DELETED = 8'hE5;

  // Sectors per cluster is a power of two, so its highest set bit is log2.
  function automatic logic [2:0] spc_log2(input logic [7:0] spc);
    spc_log2 = 3'd0;
    for (int i = 0; i < 8; i++)
      if (spc[i]) spc_log2 = 3'(i);
  endfunction

endpackage

// File: rtl/fat32_clust2lba.sv
// Registered cluster-to-LBA conversion: (clust-2)*spclust + datastart,
// with the multiply done as a shift since spclust is a power of two.
module fat32_clust2lba
  import fat32_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] clust,
  input  logic [7:0]  spclust,
  input  logic [31:0] datastart,
  output logic [31:0] lba
);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset)
      lba <= '0;
    else if (en)
      lba <= ((clust - 32'd2) << spc_log2(spclust)) + datastart;
  end

endmodule

// File: rtl/fat32_dirscan.sv
// Root-directory scanner: requests root-cluster sectors one at a time and
// searches the streamed bytes for the 8.3 entry AVC_NAME.
module fat32_dirscan
  import fat32_pkg::*;
#(
  parameter logic [87:0] AVC_NAME = "VIDEO   AVC",
  parameter int unsigned POFS     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dscen,
  input  logic        sbdone,
  input  logic [7:0]  DATASI,
  input  logic [15:0] PTDATAPNTR,
  input  logic [15:0] FAT1SA,
  input  logic [31:0] FATSIZE,
  input  logic [7:0]  SPCLUST,
  input  logic [15:0] FROOTSEC,
  output logic        dsecreq,
  output logic [31:0] DSECADDR,
  output logic        avcfound,
  output logic        avcfail,
  output logic [31:0] AVCCLUST,
  output logic [31:0] AVCSIZE,
  output logic [31:0] AVCSTARTSEC
);

  state_t      state_q, state_d;
  logic [31:0] datastart, ds_calc, root_lba;
  logic [7:0]  secnt;
  logic        ent_match;
  logic [31:0] ent_clust;
  logic [23:0] ent_size;
  logic [15:0] b;
  logic [4:0]  e;
  logic [7:0]  exp_byte;
  logic        byte_ok, sec_end, sec_last, dir_end, take_match;

  assign ds_calc  = 32'(FAT1SA) + {FATSIZE[30:0], 1'b0};
  assign root_lba = ds_calc + 32'(FROOTSEC) - 32'({SPCLUST, 1'b0});

  assign b          = PTDATAPNTR - 16'(POFS);
  assign e          = b[$clog2(DIR_ENT_SZ)-1:0];
  assign byte_ok    = (state_q == S_SCAN) && sbdone && (b < 16'(SEC_BYTES));
  assign sec_end    = (b == 16'(SEC_BYTES - 1));
  assign sec_last   = ((secnt + 8'd1) == SPCLUST);
  assign dir_end    = (e == DIRENT_NAME0) && (DATASI == DIRENT_END);
  assign take_match = (e == DIRENT_SIZE + 5'd3) && ent_match;

  assign dsecreq  = (state_q == S_REQ);
  assign avcfound = (state_q == S_DONE);
  assign avcfail  = (state_q == S_FAIL);

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    exp_byte = '0;
    for (int i = 0; i < 11; i++)
      if (e == 5'(i)) exp_byte = AVC_NAME[87 - 8*i -: 8];
  end

  always_comb begin
    state_d = state_q;
    if (!dscen) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_CALC;
        S_CALC: state_d = S_REQ;
        S_REQ:  state_d = S_SCAN;
        S_SCAN: if (byte_ok) begin
          if (dir_end)         state_d = S_FAIL;
          else if (take_match) state_d = S_LBA;
          else if (sec_end)    state_d = sec_last ? S_FAIL : S_REQ;
        end
        S_LBA:  state_d = S_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      datastart <= '0;
      DSECADDR  <= '0;
      secnt     <= '0;
      ent_match <= 1'b0;
      ent_clust <= '0;
      ent_size  <= '0;
      AVCCLUST  <= '0;
      AVCSIZE   <= '0;
    end else if (!dscen) begin
      secnt     <= '0;
      ent_match <= 1'b0;
    end else if (state_q == S_CALC) begin
      datastart <= ds_calc;
      DSECADDR  <= root_lba;
      secnt     <= '0;
    end else if (byte_ok) begin
      // Match flag: armed by name byte 0, knocked down by any later miss.
      if (e == DIRENT_NAME0)
        ent_match <= (DATASI == exp_byte) && (DATASI != DIRENT_DELETED);
      else if (e < DIRENT_ATTR)
        ent_match <= ent_match && (DATASI == exp_byte);
      else if (e == DIRENT_ATTR && |(DATASI & (ATTR_VOL | ATTR_DIR)))
        ent_match <= 1'b0;

      case (e)
        DIRENT_CLHI:        ent_clust[23:16] <= DATASI;
        DIRENT_CLHI + 5'd1: ent_clust[31:24] <= DATASI;
        DIRENT_CLLO:        ent_clust[7:0]   <= DATASI;
        DIRENT_CLLO + 5'd1: ent_clust[15:8]  <= DATASI;
        DIRENT_SIZE:        ent_size[7:0]    <= DATASI;
        DIRENT_SIZE + 5'd1: ent_size[15:8]   <= DATASI;
        DIRENT_SIZE + 5'd2: ent_size[23:16]  <= DATASI;
        default: ;
      endcase

      if (take_match) begin
        AVCCLUST <= ent_clust;
        AVCSIZE  <= {DATASI, ent_size};
      end else if (sec_end) begin
        secnt <= secnt + 8'd1;
        if (!sec_last) DSECADDR <= DSECADDR + 32'd1;
      end
    end
  end

  fat32_clust2lba u_clust2lba (
    .clk       (clk),
    .reset     (reset),
    .en        (state_q == S_LBA),
    .clust     (AVCCLUST),
    .spclust   (SPCLUST),
    .datastart (datastart),
    .lba       (AVCSTARTSEC)
  );

endmodule

// File: tb/tb_fat32_dirscan.sv
// Directed bench for fat32_dirscan: geometry 0x20/0x3C0/8/16, root LBA 0x7A0,
// sector images built in a byte array and streamed one byte per clock.
module tb_fat32_dirscan;

  logic        clk = 1'b0;
  logic        reset, dscen, sbdone;
  logic [7:0]  DATASI;
  logic [15:0] PTDATAPNTR, FAT1SA, FROOTSEC;
  logic [31:0] FATSIZE;
  logic [7:0]  SPCLUST;
  logic        dsecreq, avcfound, avcfail;
  logic [31:0] DSECADDR, AVCCLUST, AVCSIZE, AVCSTARTSEC;

  int n_vec = 0;
  int n_bad = 0;
  int req_cnt = 0;
  int base;
  logic [7:0] sec [512];

  localparam logic [87:0] NAME  = "VIDEO   AVC";
  localparam logic [87:0] OTHER = "README  TXT";

  fat32_dirscan dut (
    .clk(clk), .reset(reset), .dscen(dscen), .sbdone(sbdone),
    .DATASI(DATASI), .PTDATAPNTR(PTDATAPNTR), .FAT1SA(FAT1SA),
    .FATSIZE(FATSIZE), .SPCLUST(SPCLUST), .FROOTSEC(FROOTSEC),
    .dsecreq(dsecreq), .DSECADDR(DSECADDR), .avcfound(avcfound),
    .avcfail(avcfail), .AVCCLUST(AVCCLUST), .AVCSIZE(AVCSIZE),
    .AVCSTARTSEC(AVCSTARTSEC)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (dsecreq === 1'b1) req_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  task automatic put_entry(input int idx, input logic [87:0] nm, input logic [7:0] attr,
                           input logic [31:0] cl, input logic [31:0] sz);
    int bs;
    bs = idx * 32;
    for (int k = 0; k < 32; k++) sec[bs + k] = 8'h00;
    for (int k = 0; k < 11; k++) sec[bs + k] = nm[87 - 8*k -: 8];
    sec[bs + 11] = attr;
    sec[bs + 20] = cl[23:16];
    sec[bs + 21] = cl[31:24];
    sec[bs + 26] = cl[7:0];
    sec[bs + 27] = cl[15:8];
    for (int k = 0; k < 4; k++) sec[bs + 28 + k] = sz[8*k +: 8];
  endtask

  task automatic fill_other();
    for (int i = 0; i < 16; i++) put_entry(i, OTHER, 8'h20, 32'd3, 32'd100);
  endtask

  task automatic feed(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      DATASI = sec[i];
      PTDATAPNTR = 16'(i + 1);
      sbdone = 1'b1;
      @(negedge clk);
    end
    sbdone = 1'b0;
  endtask

  // Bounded wait for a request pulse, checks its address, then steps into SCAN.
  task automatic wait_req(input string tag, input logic [31:0] exp_addr);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (dsecreq === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    check({tag, "_addr"}, DSECADDR, exp_addr);
    @(negedge clk);
  endtask

  task automatic restart();
    dscen = 1'b0;
    @(negedge clk);
    @(negedge clk);
    base = req_cnt;
    dscen = 1'b1;
  endtask

  initial begin
    reset = 1'b1; dscen = 1'b0; sbdone = 1'b0; DATASI = '0; PTDATAPNTR = '0;
    FAT1SA = 16'h0020; FATSIZE = 32'h3C0; SPCLUST = 8'd8; FROOTSEC = 16'd16;
    @(negedge clk);
    @(negedge clk);
    check("rst_dsecreq", 32'(dsecreq), 32'd0);
    check("rst_found", 32'(avcfound), 32'd0);
    check("rst_fail", 32'(avcfail), 32'd0);
    check("rst_addr", DSECADDR, 32'd0);
    check("rst_clust", AVCCLUST, 32'd0);
    check("rst_size", AVCSIZE, 32'd0);
    check("rst_startsec", AVCSTARTSEC, 32'd0);
    reset = 1'b0;

    // Match in entry 3 of the first root sector.
    fill_other();
    put_entry(3, NAME, 8'h20, 32'h0000_0005, 32'h0012_3456);
    restart();
    wait_req("a_req", 32'h7A0);
    feed(0, 127);
    check("a_found_lat1", 32'(avcfound), 32'd0);
    @(negedge clk);
    check("a_found_lat2", 32'(avcfound), 32'd1);
    check("a_clust", AVCCLUST, 32'h0000_0005);
    check("a_size", AVCSIZE, 32'h0012_3456);
    check("a_startsec", AVCSTARTSEC, 32'h7B8);
    check("a_reqcnt", 32'(req_cnt - base), 32'd1);

    // No match in sector 0, match with a high cluster word in sector 1.
    fill_other();
    restart();
    wait_req("b_req0", 32'h7A0);
    feed(0, 511);
    wait_req("b_req1", 32'h7A1);
    put_entry(0, NAME, 8'h20, 32'h0001_0002, 32'h0000_0010);
    feed(0, 31);
    @(negedge clk);
    check("b_found", 32'(avcfound), 32'd1);
    check("b_clust", AVCCLUST, 32'h0001_0002);
    check("b_size", AVCSIZE, 32'h0000_0010);
    check("b_startsec", AVCSTARTSEC, 32'h0008_07A0);

    // End-of-directory marker in entry 0.
    fill_other();
    sec[0] = 8'h00;
    restart();
    wait_req("c_req", 32'h7A0);
    feed(0, 63);
    check("c_fail", 32'(avcfail), 32'd1);
    check("c_found", 32'(avcfound), 32'd0);
    check("c_reqcnt", 32'(req_cnt - base), 32'd1);

    // Deleted and directory copies precede the real entry.
    fill_other();
    put_entry(0, {8'hE5, 80'("IDEO   AVC")}, 8'h20, 32'd7, 32'h11);
    put_entry(1, NAME, 8'h10, 32'd8, 32'h22);
    put_entry(2, NAME, 8'h20, 32'd9, 32'h200);
    restart();
    wait_req("d_req", 32'h7A0);
    feed(0, 95);
    @(negedge clk);
    check("d_found", 32'(avcfound), 32'd1);
    check("d_clust", AVCCLUST, 32'd9);
    check("d_size", AVCSIZE, 32'h200);
    check("d_startsec", AVCSTARTSEC, 32'h7D8);

    // Whole root cluster (8 sectors) without a match.
    fill_other();
    restart();
    wait_req("e_req0", 32'h7A0);
    for (int s = 0; s < 8; s++) begin
      if (s > 0) wait_req("e_reqn", 32'h7A0 + 32'(s));
      feed(0, 511);
    end
    check("e_fail", 32'(avcfail), 32'd1);
    check("e_reqcnt", 32'(req_cnt - base), 32'd8);

    // Enable dropped mid-scan: flags clear, found fields retained.
    restart();
    wait_req("f_req", 32'h7A0);
    feed(0, 69);
    dscen = 1'b0;
    @(negedge clk);
    check("f_found", 32'(avcfound), 32'd0);
    check("f_fail", 32'(avcfail), 32'd0);
    check("f_dsecreq", 32'(dsecreq), 32'd0);
    check("f_clust_kept", AVCCLUST, 32'd9);

    // Reset mid-scan clears everything.
    restart();
    wait_req("g_req", 32'h7A0);
    feed(0, 49);
    reset = 1'b1;
    @(negedge clk);
    check("g_addr", DSECADDR, 32'd0);
    check("g_clust", AVCCLUST, 32'd0);
    check("g_size", AVCSIZE, 32'd0);
    check("g_startsec", AVCSTARTSEC, 32'd0);
    check("g_dsecreq", 32'(dsecreq), 32'd0);
    reset = 1'b0;
    dscen = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
